qpsk_bit_packer: RTL

QPSK_BIT_PACKER -- requirements
Module: qpsk_bit_packer

---
 rtl/qpsk_bit_packer_pkg.sv | 45 ++++
 rtl/sync_fifo.sv | 74 +++++++
 rtl/qpsk_bit_packer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/qpsk_bit_packer_pkg.sv
// Shared constants, payload types and the pair-placement helper for the
// QPSK bit packer. These are the same framing constants the QPSK
// demodulator and modulator wrappers use.
package qpsk_bit_packer_pkg;

    localparam int unsigned SYMS_PER_BYTE  = 4;
    localparam int unsigned BITS_PER_SYM   = 2;
    localparam int unsigned BYTE_W         = SYMS_PER_BYTE * BITS_PER_SYM;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned SYM_CNT_W      = 2;
    localparam int unsigned BIT_IDX_W      = 3;

    // One demodulated symbol: odd bit arrives first in time, even bit second.
    typedef struct packed {
        logic odd;
        logic even;
    } qpsk_pair_t;

    typedef logic [BYTE_W-1:0] byte_t;

    // Write one pair into its byte position for symbol slot cnt (0..3).
    // MSB-first: slot k -> bits {7-2k, 6-2k}; LSB-first: slot k -> bits {2k, 2k+1}.
    function automatic byte_t place_pair(
        input byte_t                acc,
        input logic [SYM_CNT_W-1:0] cnt,
        input qpsk_pair_t           pair,
        input logic                 msb_first
    );
        byte_t                r;
        logic [BIT_IDX_W-1:0] odd_idx;
        logic [BIT_IDX_W-1:0] even_idx;
        r = acc;
        if (msb_first) begin
            odd_idx  = BIT_IDX_W'(3'd7 - {cnt, 1'b0});
            even_idx = BIT_IDX_W'(3'd6 - {cnt, 1'b0});
        end else begin
            odd_idx  = {cnt, 1'b0};
            even_idx = {cnt, 1'b1};
        end
        r[odd_idx]  = pair.odd;
        r[even_idx] = pair.even;
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage, wrapping pointers and an
// occupancy counter. The caller guarantees no push when full and no pop
// when empty. dout always shows the entry at the read pointer.
// Ports:
//   clk, rst_n  clock, async active-low reset (clears storage, pointers, fill)
//   push, din   write strobe and data
//   pop         read strobe (advances the head)
//   dout        head entry
//   fill        occupancy 0..DEPTH
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    // Next-state: DEPTH is a power of two, so pointers wrap naturally.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        fill_d = fill_q;
        if (push) begin
            mem_d[wptr_q] = din;
            wptr_d        = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase
    end

    // State registers; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            fill_q <= fill_d;
        end
    end

    assign dout = mem_q[rptr_q];
    assign fill = fill_q;

endmodule

// File: rtl/qpsk_bit_packer.sv
// Packs demodulated QPSK bit pairs (odd bit first, even bit second) into
// bytes, four pairs per byte, and queues the bytes in an output FIFO.
// A flush pulse emits a partial byte with unfilled positions zero.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   sym_valid/sym_odd/sym_even  incoming bit pair, sym_ready = FIFO not full
//   flush                       emit any partial byte
//   byte_data/byte_valid/byte_ready  output byte stream (FIFO head)
//   overflow, ovf_clr           sticky dropped-pair flag and its clear
//   fill                        output FIFO occupancy
module qpsk_bit_packer
    import qpsk_bit_packer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sym_valid,
    input  logic                          sym_odd,
    input  logic                          sym_even,
    output logic                          sym_ready,
    input  logic                          flush,
    output logic [BYTE_W-1:0]             byte_data,
    output logic                          byte_valid,
    input  logic                          byte_ready,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fill
);

    localparam int unsigned FILL_W = $clog2(FIFO_DEPTH) + 1;

    // Elaboration-time guard on the supported FIFO depths.
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("qpsk_bit_packer: FIFO_DEPTH must be a power of two in 2..16");
    end

    logic [SYM_CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    byte_t                acc_q, acc_d;
    logic                 overflow_q, overflow_d;

    qpsk_pair_t           pair;
    logic                 accept;
    logic                 fifo_full;
    logic                 fifo_push;
    logic                 fifo_pop;
    byte_t                fifo_din;
    byte_t                fifo_dout;
    logic [FILL_W-1:0]    fifo_fill;
    byte_t                acc_next;
    logic                 has_bits;

    assign pair       = {sym_odd, sym_even};
    assign fifo_full  = (fifo_fill == FILL_W'(FIFO_DEPTH));
    assign sym_ready  = !fifo_full;
    assign accept     = sym_valid && sym_ready;
    assign byte_valid = (fifo_fill != '0);
    assign fifo_pop   = byte_valid && byte_ready;

    // Accumulator and flush: the accepted pair is placed first, then a byte
    // is pushed if it is complete or a flush finds any bits pending.
    always_comb begin
        sym_cnt_d  = sym_cnt_q;
        acc_d      = acc_q;
        overflow_d = overflow_q;
        fifo_push  = 1'b0;
        acc_next   = acc_q;
        has_bits   = (sym_cnt_q != '0);

        if (accept) begin
            acc_next = place_pair(acc_q, sym_cnt_q, pair, MSB_FIRST);
            has_bits = 1'b1;
        end

        if (accept && sym_cnt_q == SYM_CNT_W'(SYMS_PER_BYTE - 1)) begin
            fifo_push = 1'b1;
        end else if (flush && has_bits && !fifo_full) begin
            fifo_push = 1'b1;
        end

        if (fifo_push) begin
            acc_d     = '0;
            sym_cnt_d = '0;
        end else if (accept) begin
            acc_d     = acc_next;
            sym_cnt_d = sym_cnt_q + SYM_CNT_W'(1);
        end

        // A new drop event outranks a simultaneous clear.
        if (sym_valid && !sym_ready) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    assign fifo_din = acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_cnt_q  <= '0;
            acc_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            sym_cnt_q  <= sym_cnt_d;
            acc_q      <= acc_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .fill  (fifo_fill)
    );

    assign byte_data = fifo_dout;
    assign overflow  = overflow_q;
    assign fill      = fifo_fill;

endmodule
